pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter OPC_W, default 4: opcode width, taken from the top bits of instr.
REQ-002 Parameter REG_W, default 4: register-specifier width; INSTR_W = OPC_W + 3*REG_W, which is 16 at the defaults.
REQ-003 Parameter DRAIN_CYCLES, default 3: cycles from HLT acceptance to halted; legal range 1 or more.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port list (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  INSTR_W  IF/ID instruction; fields are rd = [3*REG_W-1:2*REG_W], rs = [2*REG_W-1:REG_W], rt = [REG_W-1:0].
- instr_vld  in  1  instr holds a real instruction.
- stall_in  in  1  external freeze request (memory busy).
- flush  in  1  branch taken in EX; the instruction in ID is wrong-path.
- MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, tophalf, pcs, hlt  out  1 each  registered ID/EX control bundle.
- id_ex_vld  out  1  ID/EX holds a real instruction.
- id_ex_rd  out  REG_W  registered destination register.
- stall_out  out  1  combinational; freezes PC and IF/ID.
- halted  out  1  processor halted.

Function
REQ-006 Decode table, with every unlisted signal at 0:
- 0x0-0x7 (ALU ops): RegWrite=1, ALUOp=1; ALUSrc=1 only for 0x4-0x6.
- 0x8 LW: MemRead, MemtoReg, ALUSrc, RegWrite.
- 0x9 SW: MemWrite, ALUSrc.
- 0xA LHB: ALUSrc, RegWrite, tophalf.
- 0xB LLB: ALUSrc, RegWrite.
- 0xC B and 0xD BR: all 0.
- 0xE PCS: RegWrite, pcs.
- 0xF HLT: hlt.
REQ-007 When OPC_W > 4, any opcode value above 0xF decodes as HLT.
REQ-008 ID/EX update priority at each rising edge, highest first:
- (1) flush or state != RUN: load a bubble (all controls 0, id_ex_vld=0, id_ex_rd=0).
- (2) load-use hazard: load a bubble.
- (3) stall_in: hold the current contents.
- (4) otherwise: load the decode when instr_vld=1, or a bubble when instr_vld=0.
REQ-009 Load-use hazard is true when id_ex_vld & MemRead & instr_vld & (id_ex_rd != 0) & (id_ex_rd == rs or id_ex_rd == rt).
REQ-010 stall_out = (hazard & !flush) | stall_in | (state != RUN); latency 0 cycles.
REQ-011 A hazard lasts exactly one cycle: the inserted bubble clears the condition on the next cycle.
REQ-012 Halt FSM has three states, RUN, DRAIN and HALTED, with a counter cnt of width clog2(DRAIN_CYCLES+1).
REQ-013 RUN -> DRAIN when an HLT is loaded into ID/EX under REQ-008 case (4); cnt <= DRAIN_CYCLES-1 on that edge.
REQ-014 DRAIN: while cnt != 0, each edge decrements cnt; on the edge where cnt == 0, the FSM goes to HALTED.
REQ-015 Flush asserted in DRAIN means the HLT was wrong-path: next state RUN, cnt <= 0.
REQ-016 Flush has no effect in HALTED.
REQ-017 HALTED is absorbing until reset; halted = (state == HALTED).
REQ-018 HLT arriving while stall_in=1 is not accepted; the FSM stays in RUN.

Reset
REQ-019 rst_n low, at any time including DRAIN or HALTED, immediately drives all of the following to 0: every registered output, id_ex_rd, cnt, and halted; state becomes RUN.
REQ-020 While rst_n is low and stall_in=0, stall_out is 0.
REQ-021 The first edge after rst_n rises follows REQ-008 normally.

Configuration
REQ-022 Macro HAZARD_DETECT_EN defined: load-use detection per REQ-009 and REQ-011.
REQ-023 Macro HAZARD_DETECT_EN undefined: hazard is constant 0 and stall_out = stall_in | (state != RUN); all other behaviour is identical.

Verification (defaults; DRAIN_CYCLES=3)
REQ-024 instr=0x0123, vld=1 -> after one edge: id_ex_vld=1, RegWrite=1, ALUOp=1, ALUSrc=0, id_ex_rd=1, stall_out=0.
REQ-025 LW 0x8450, then ADD 0x0546 (rs=4) -> stall_out=1 for one cycle and one bubble, then ADD in ID/EX; with the macro undefined, no stall.
REQ-026 LW 0x8050, then 0x0106 (rs=0) -> no stall.
REQ-027 HLT 0xF000 accepted at edge N -> stall_out=1 from N; halted=1 after edge N+3; flush pulse after edge N+1 -> state RUN, halted stays 0.
REQ-028 flush=1, stall_in=1, instr=0x0123 vld=1 together -> bubble loaded (id_ex_vld=0), stall_out=1.
REQ-029 rst_n low mid-HALTED, asynchronous to clk -> halted=0 and all outputs 0 before the next edge; after release, 0x0123 is decoded normally.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit: opcode decode into the ID/EX control bundle, load-use stall, and HLT drain FSM.
// Define HAZARD_DETECT_EN to enable load-use hazard detection; otherwise the hazard term is tied off.
module pipe_ctrl_unit #(
  parameter int OPC_W        = 4,
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3,
  localparam int INSTR_W     = OPC_W + 3*REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_vld,
  input  logic               stall_in,
  input  logic               flush,
  output logic               MemRead,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               ALUOp,
  output logic               tophalf,
  output logic               pcs,
  output logic               hlt,
  output logic               id_ex_vld,
  output logic [REG_W-1:0]   id_ex_rd,
  output logic               stall_out,
  output logic               halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic alu_op;
    logic tophalf;
    logic pcs;
    logic hlt;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [OPC_W-1:0] opc);
    ctrl_t c;
    logic [31:0] op;
    c  = '0;
    op = 32'(opc);
    case (op)
      32'h0, 32'h1, 32'h2, 32'h3, 32'h7: begin
        c.reg_write = 1'b1;
        c.alu_op    = 1'b1;
      end
      32'h4, 32'h5, 32'h6: begin
        c.reg_write = 1'b1;
        c.alu_op    = 1'b1;
        c.alu_src   = 1'b1;
      end
      32'h8: begin
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.reg_write  = 1'b1;
      end
      32'h9: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      32'hA: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.tophalf   = 1'b1;
      end
      32'hB: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      32'hC, 32'hD: c = '0;
      32'hE: begin
        c.reg_write = 1'b1;
        c.pcs       = 1'b1;
      end
      // 0xF and anything wider than the base opcode space halts
      default: c.hlt = 1'b1;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             vld_q, vld_d;
  logic [REG_W-1:0] rd_q, rd_d;

  ctrl_t            dec;
  logic [REG_W-1:0] instr_rd;
  logic             hazard;
  logic             accept_hlt;

  assign dec      = decode(instr[INSTR_W-1 -: OPC_W]);
  assign instr_rd = instr[3*REG_W-1:2*REG_W];

`ifdef HAZARD_DETECT_EN
  logic [REG_W-1:0] instr_rs;
  logic [REG_W-1:0] instr_rt;
  assign instr_rs = instr[2*REG_W-1:REG_W];
  assign instr_rt = instr[REG_W-1:0];
  assign hazard   = vld_q & ctrl_q.mem_read & instr_vld & (rd_q != '0) &
                    ((rd_q == instr_rs) | (rd_q == instr_rt));
`else
  logic hazard_unused;
  assign hazard_unused = &{1'b0, instr[2*REG_W-1:0]};
  assign hazard        = 1'b0;
`endif

  assign accept_hlt = (state_q == RUN) & ~flush & ~hazard & ~stall_in & instr_vld & dec.hlt;

  always_comb begin
    ctrl_d = ctrl_q;
    vld_d  = vld_q;
    rd_d   = rd_q;
    if (flush || (state_q != RUN) || hazard) begin
      ctrl_d = '0;
      vld_d  = 1'b0;
      rd_d   = '0;
    end else if (!stall_in) begin
      if (instr_vld) begin
        ctrl_d = dec;
        vld_d  = 1'b1;
        rd_d   = instr_rd;
      end else begin
        ctrl_d = '0;
        vld_d  = 1'b0;
        rd_d   = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept_hlt) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        // a flush here means the HLT itself was on the wrong path
        if (flush) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      vld_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
    end
  end

  assign stall_out = (hazard & ~flush) | stall_in | (state_q != RUN);
  assign halted    = (state_q == HALTED);

  assign MemRead   = ctrl_q.mem_read;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign MemWrite  = ctrl_q.mem_write;
  assign ALUSrc    = ctrl_q.alu_src;
  assign RegWrite  = ctrl_q.reg_write;
  assign ALUOp     = ctrl_q.alu_op;
  assign tophalf   = ctrl_q.tophalf;
  assign pcs       = ctrl_q.pcs;
  assign hlt       = ctrl_q.hlt;
  assign id_ex_vld = vld_q;
  assign id_ex_rd  = rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit at default parameters; control bundle compared as
// {MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp,tophalf,pcs,hlt}.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_vld;
  logic        stall_in;
  logic        flush;
  logic        MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, tophalf, pcs, hlt;
  logic        id_ex_vld;
  logic [3:0]  id_ex_rd;
  logic        stall_out;
  logic        halted;

  int vectors = 0;
  int errs    = 0;

  logic [8:0] ctl;
  assign ctl = {MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, tophalf, pcs, hlt};

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_vld(instr_vld),
    .stall_in(stall_in), .flush(flush),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .tophalf(tophalf), .pcs(pcs), .hlt(hlt),
    .id_ex_vld(id_ex_vld), .id_ex_rd(id_ex_rd), .stall_out(stall_out), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] tbl_instr [6];
  logic [8:0]  tbl_ctl   [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; instr = 16'h0; instr_vld = 1'b0; stall_in = 1'b0; flush = 1'b0;
    #23;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_vld", 32'(id_ex_vld), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stall_out", 32'(stall_out), 32'h0);
    rst_n = 1'b1;
    step();

    // plain ALU op
    instr = 16'h0123; instr_vld = 1'b1;
    #1 chk("add_stall_pre", 32'(stall_out), 32'h0);
    step();
    chk("add_ctl", 32'(ctl), 32'h018);
    chk("add_vld", 32'(id_ex_vld), 32'h1);
    chk("add_rd", 32'(id_ex_rd), 32'h1);
    chk("add_stall", 32'(stall_out), 32'h0);

    // LW then dependent ADD
    instr = 16'h8450;
    step();
    chk("lw_ctl", 32'(ctl), 32'h1B0);
    chk("lw_rd", 32'(id_ex_rd), 32'h4);
    instr = 16'h0546;
    #1;
`ifdef HAZARD_DETECT_EN
    chk("lu_stall", 32'(stall_out), 32'h1);
    step();
    chk("lu_bubble_vld", 32'(id_ex_vld), 32'h0);
    chk("lu_bubble_ctl", 32'(ctl), 32'h0);
    chk("lu_stall_clear", 32'(stall_out), 32'h0);
    step();
`else
    chk("lu_nostall", 32'(stall_out), 32'h0);
    step();
`endif
    chk("lu_add_vld", 32'(id_ex_vld), 32'h1);
    chk("lu_add_rd", 32'(id_ex_rd), 32'h5);
    chk("lu_add_ctl", 32'(ctl), 32'h018);

    // LW to r0 followed by reader of r0: never a hazard
    instr = 16'h8050;
    step();
    instr = 16'h0106;
    #1 chk("r0_nostall", 32'(stall_out), 32'h0);
    step();
    chk("r0_add_rd", 32'(id_ex_rd), 32'h1);
    chk("r0_add_vld", 32'(id_ex_vld), 32'h1);

    // decode table spot checks
    tbl_instr[0] = 16'h4123; tbl_ctl[0] = 9'h038;
    tbl_instr[1] = 16'h7123; tbl_ctl[1] = 9'h018;
    tbl_instr[2] = 16'h9123; tbl_ctl[2] = 9'h060;
    tbl_instr[3] = 16'hA123; tbl_ctl[3] = 9'h034;
    tbl_instr[4] = 16'hB123; tbl_ctl[4] = 9'h030;
    tbl_instr[5] = 16'hE123; tbl_ctl[5] = 9'h012;
    for (int i = 0; i < 6; i++) begin
      instr = tbl_instr[i];
      step();
      chk($sformatf("dec_%h_ctl", tbl_instr[i][15:12]), 32'(ctl), 32'(tbl_ctl[i]));
    end
    instr = 16'hC123;
    step();
    chk("dec_b_ctl", 32'(ctl), 32'h0);
    chk("dec_b_vld", 32'(id_ex_vld), 32'h1);

    // invalid slot loads a bubble
    instr_vld = 1'b0;
    step();
    chk("novld_vld", 32'(id_ex_vld), 32'h0);
    chk("novld_rd", 32'(id_ex_rd), 32'h0);

    // stall_in holds ID/EX
    instr = 16'h0123; instr_vld = 1'b1;
    step();
    instr = 16'h8450; stall_in = 1'b1;
    #1 chk("hold_stall_out", 32'(stall_out), 32'h1);
    step();
    chk("hold_ctl", 32'(ctl), 32'h018);
    chk("hold_rd", 32'(id_ex_rd), 32'h1);

    // flush beats stall_in
    instr = 16'h0123; flush = 1'b1;
    #1 chk("flush_stall_out", 32'(stall_out), 32'h1);
    step();
    chk("flush_vld", 32'(id_ex_vld), 32'h0);
    flush = 1'b0;

    // HLT under stall_in is not accepted
    instr = 16'hF000;
    step();
    stall_in = 1'b0; instr_vld = 1'b0;
    #1 chk("hlt_stalled_state", 32'(stall_out), 32'h0);
    chk("hlt_stalled_halted", 32'(halted), 32'h0);

    // HLT accepted, then cancelled by a flush during drain
    instr_vld = 1'b1;
    step();
    instr_vld = 1'b0;
    chk("hlt_ctl", 32'(ctl), 32'h001);
    chk("hlt_drain_stall", 32'(stall_out), 32'h1);
    step();
    chk("hlt_drain_n1", 32'(halted), 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 chk("hlt_cancel_stall", 32'(stall_out), 32'h0);
    step(); step(); step();
    chk("hlt_cancel_halted", 32'(halted), 32'h0);

    // HLT runs to completion
    instr_vld = 1'b1;
    step();
    instr_vld = 1'b0;
    step();
    chk("hlt_n1", 32'(halted), 32'h0);
    step();
    chk("hlt_n2", 32'(halted), 32'h0);
    step();
    chk("hlt_n3", 32'(halted), 32'h1);
    chk("hlt_n3_stall", 32'(stall_out), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halted_flush", 32'(halted), 32'h1);
    instr = 16'h0123; instr_vld = 1'b1;
    step();
    chk("halted_bubble", 32'(id_ex_vld), 32'h0);

    // asynchronous reset out of HALTED
    instr_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_ctl", 32'(ctl), 32'h0);
    chk("arst_stall_out", 32'(stall_out), 32'h0);
    #1 rst_n = 1'b1;
    instr = 16'h0123; instr_vld = 1'b1;
    step();
    chk("post_rst_ctl", 32'(ctl), 32'h018);
    chk("post_rst_rd", 32'(id_ex_rd), 32'h1);
    chk("post_rst_vld", 32'(id_ex_vld), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
